// File: rtl/jtkiwi_pkg.sv
// Shared constants for the kiwi shared-RAM arbiter.
//   - FSM state encoding (legacy 2-bit localparams)
//   - legal ranges for the NPORT / AW / DW parameters
//   - idx_width(): width of a port index for a given port count
package jtkiwi_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t StIdle   = 2'd0;
    localparam arb_state_t StAccess = 2'd1;
    localparam arb_state_t StDone   = 2'd2;

    localparam int unsigned NPORT_MIN = 2;
    localparam int unsigned NPORT_MAX = 4;
    localparam int unsigned AW_MIN    = 1;
    localparam int unsigned AW_MAX    = 20;
    localparam int unsigned DW_MIN    = 1;
    localparam int unsigned DW_MAX    = 32;

    // Bits needed to hold a port index in 0..n-1 (n limited to 2..4).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 2) ? 2 : 1;
    endfunction

endpackage

// File: rtl/jtkiwi_shr_arb_if.sv
// CPU-side bus of the shared-RAM arbiter, all ports packed side by side.
//   cs    per-port request, held high until ok
//   we    per-port write strobe, sampled with cs
//   addr  port i at [i*AW +: AW]
//   din   port i at [i*DW +: DW]
//   dout  port i at [i*DW +: DW], valid while ok[i] is high
//   ok    per-port access-complete flag (one-hot or zero)
//   busy  arbiter not idle
// master: the CPU side (bench), slave: the arbiter.
interface jtkiwi_shr_arb_if #(
    parameter int unsigned NPORT = 2,
    parameter int unsigned AW    = 13,
    parameter int unsigned DW    = 8
);
    logic [NPORT-1:0]    cs;
    logic [NPORT-1:0]    we;
    logic [NPORT*AW-1:0] addr;
    logic [NPORT*DW-1:0] din;
    logic [NPORT*DW-1:0] dout;
    logic [NPORT-1:0]    ok;
    logic                busy;

    modport master (
        output cs, we, addr, din,
        input  dout, ok, busy
    );

    modport slave (
        input  cs, we, addr, din,
        output dout, ok, busy
    );

endinterface

// File: rtl/jtkiwi_shr_ram.sv
// Single-port shared RAM, 2^AW x DW, synchronous read.
//   clk     system clock
//   en_i    perform one access on this edge
//   we_i    1 = write din_i, 0 = read
//   addr_i  word address
//   din_i   write data
//   dout_o  registered data of the last access (written data on a write)
// Contents are never reset.
module jtkiwi_shr_ram #(
    parameter int unsigned AW = 13,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o
);

    logic [DW-1:0] mem [0:(2**AW)-1];
    logic [DW-1:0] dout_q;

    // Write-first: a write returns its own data so the port sees it on dout.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem[addr_i] <= din_i;
                dout_q      <= din_i;
            end else begin
                dout_q      <= mem[addr_i];
            end
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/jtkiwi_shr_arb.sv
// Arbiter giving NPORT CPU ports access to one single-port shared RAM.
//   clk   system clock (24 MHz in the kiwi core)
//   rst   asynchronous active-high reset
//   bus   slave side of jtkiwi_shr_arb_if (cs/we/addr/din in, dout/ok/busy out)
// Parameters: NPORT (2..4), AW, DW, RR (1 = round-robin, 0 = fixed priority,
// port 0 highest).
// Flow per access: IDLE picks a winner and latches its request, ACCESS runs
// one RAM cycle, DONE holds ok[winner] until the winner drops cs. ok rises two
// clocks after cs is seen in IDLE.
module jtkiwi_shr_arb
    import jtkiwi_pkg::*;
#(
    parameter int unsigned NPORT = 2,
    parameter int unsigned AW    = 13,
    parameter int unsigned DW    = 8,
    parameter int unsigned RR    = 1
) (
    input  logic              clk,
    input  logic              rst,
    jtkiwi_shr_arb_if.slave   bus
);

    localparam int unsigned IW = idx_width(NPORT);

    // Unpacked views of the packed bus.
    logic [AW-1:0] addr_a [NPORT];
    logic [DW-1:0] din_a  [NPORT];

    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            addr_a[i] = bus.addr[i*AW +: AW];
            din_a[i]  = bus.din[i*DW +: DW];
        end
    end

    // State and latched request.
    arb_state_t    st_q,   st_d;
    logic [IW-1:0] ptr_q,  ptr_d;
    logic [IW-1:0] win_q,  win_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q,   we_d;
    logic [DW-1:0] din_q,  din_d;
    // Last value served to each port; the current winner's slice is
    // overridden by live RAM data while in DONE.
    logic [DW-1:0] dout_q [NPORT];
    logic [DW-1:0] dout_d [NPORT];

    logic [DW-1:0] ram_dout;

    // Winner selection: scan from ptr (round-robin) or from port 0.
    int unsigned   scan;
    logic [IW-1:0] sel;
    logic [IW-1:0] pick;
    logic          found;

    always_comb begin
        scan  = 0;
        sel   = '0;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NPORT; k++) begin
            if (RR != 0) begin
                scan = (32'(ptr_q) + k) % NPORT;
            end else begin
                scan = k;
            end
            sel = IW'(scan);
            if (!found && bus.cs[sel]) begin
                found = 1'b1;
                pick  = sel;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        st_d   = st_q;
        ptr_d  = ptr_q;
        win_d  = win_q;
        addr_d = addr_q;
        we_d   = we_q;
        din_d  = din_q;
        dout_d = dout_q;
        unique case (st_q)
            StIdle: begin
                if (found) begin
                    st_d   = StAccess;
                    win_d  = pick;
                    addr_d = addr_a[pick];
                    we_d   = bus.we[pick];
                    din_d  = din_a[pick];
                end
            end
            StAccess: begin
                st_d = StDone;
            end
            StDone: begin
                // Only the winner's cs is watched here, so edits to its
                // addr/we/din while cs stays high cannot start a new access.
                if (!bus.cs[win_q]) begin
                    st_d          = StIdle;
                    dout_d[win_q] = ram_dout;
                    if (RR != 0) begin
                        if (win_q == IW'(NPORT - 1)) begin
                            ptr_d = '0;
                        end else begin
                            ptr_d = win_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                st_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= StIdle;
            ptr_q  <= '0;
            win_q  <= '0;
            addr_q <= '0;
            we_q   <= 1'b0;
            din_q  <= '0;
            for (int i = 0; i < NPORT; i++) begin
                dout_q[i] <= '0;
            end
        end else begin
            st_q   <= st_d;
            ptr_q  <= ptr_d;
            win_q  <= win_d;
            addr_q <= addr_d;
            we_q   <= we_d;
            din_q  <= din_d;
            for (int i = 0; i < NPORT; i++) begin
                dout_q[i] <= dout_d[i];
            end
        end
    end

    // The RAM enable is decoded from the state register, so an asynchronous
    // reset during ACCESS drops it before the next edge and no write commits.
    jtkiwi_shr_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk    (clk),
        .en_i   (st_q == StAccess),
        .we_i   (we_q),
        .addr_i (addr_q),
        .din_i  (din_q),
        .dout_o (ram_dout)
    );

    // Outputs.
    logic [NPORT-1:0]    ok;
    logic [NPORT*DW-1:0] dout;

    always_comb begin
        ok = '0;
        for (int i = 0; i < NPORT; i++) begin
            dout[i*DW +: DW] = dout_q[i];
        end
        if (st_q == StDone) begin
            ok[win_q] = 1'b1;
            for (int i = 0; i < NPORT; i++) begin
                if (win_q == IW'(i)) begin
                    dout[i*DW +: DW] = ram_dout;
                end
            end
        end
    end

    assign bus.ok   = ok;
    assign bus.dout = dout;
    assign bus.busy = (st_q != StIdle);

endmodule

// File: tb/tb_jtkiwi_shr_arb.sv
// Bench for jtkiwi_shr_arb: three instances (2 ports RR, 2 ports fixed
// priority, 4 ports RR) driven from one linear sequence, checked against a
// transaction-level model (memory array, pointer, last-served data).
module tb_jtkiwi_shr_arb;

    localparam int AW = 13;
    localparam int DW = 8;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Bench-side request fields, 4 ports wide for every instance.
    logic [3:0]    cs_r   [ND];
    logic [3:0]    we_r   [ND];
    logic [AW-1:0] addr_r [ND][4];
    logic [DW-1:0] din_r  [ND][4];
    logic [3:0]    ok_w   [ND];
    logic [DW-1:0] dout_w [ND][4];
    logic          busy_w [ND];

    jtkiwi_shr_arb_if #(.NPORT(2), .AW(AW), .DW(DW)) bus0 ();
    jtkiwi_shr_arb_if #(.NPORT(2), .AW(AW), .DW(DW)) bus1 ();
    jtkiwi_shr_arb_if #(.NPORT(4), .AW(AW), .DW(DW)) bus2 ();

    jtkiwi_shr_arb #(.NPORT(2), .AW(AW), .DW(DW), .RR(1)) u_dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );
    jtkiwi_shr_arb #(.NPORT(2), .AW(AW), .DW(DW), .RR(0)) u_dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );
    jtkiwi_shr_arb #(.NPORT(4), .AW(AW), .DW(DW), .RR(1)) u_dut2 (
        .clk (clk), .rst (rst), .bus (bus2)
    );

    assign bus0.cs   = cs_r[0][1:0];
    assign bus0.we   = we_r[0][1:0];
    assign bus0.addr = {addr_r[0][1], addr_r[0][0]};
    assign bus0.din  = {din_r[0][1], din_r[0][0]};
    assign bus1.cs   = cs_r[1][1:0];
    assign bus1.we   = we_r[1][1:0];
    assign bus1.addr = {addr_r[1][1], addr_r[1][0]};
    assign bus1.din  = {din_r[1][1], din_r[1][0]};
    assign bus2.cs   = cs_r[2];
    assign bus2.we   = we_r[2];
    assign bus2.addr = {addr_r[2][3], addr_r[2][2], addr_r[2][1], addr_r[2][0]};
    assign bus2.din  = {din_r[2][3], din_r[2][2], din_r[2][1], din_r[2][0]};

    assign ok_w[0]      = {2'b00, bus0.ok};
    assign ok_w[1]      = {2'b00, bus1.ok};
    assign ok_w[2]      = bus2.ok;
    assign busy_w[0]    = bus0.busy;
    assign busy_w[1]    = bus1.busy;
    assign busy_w[2]    = bus2.busy;
    assign dout_w[0][0] = bus0.dout[7:0];
    assign dout_w[0][1] = bus0.dout[15:8];
    assign dout_w[0][2] = 8'h00;
    assign dout_w[0][3] = 8'h00;
    assign dout_w[1][0] = bus1.dout[7:0];
    assign dout_w[1][1] = bus1.dout[15:8];
    assign dout_w[1][2] = 8'h00;
    assign dout_w[1][3] = 8'h00;
    assign dout_w[2][0] = bus2.dout[7:0];
    assign dout_w[2][1] = bus2.dout[15:8];
    assign dout_w[2][2] = bus2.dout[23:16];
    assign dout_w[2][3] = bus2.dout[31:24];

    // Reference model.
    int          nport_of [ND] = '{2, 2, 4};
    int          rr_of    [ND] = '{1, 0, 1};
    logic [7:0]  mem_m    [ND][8192];
    bit          vld_m    [ND][8192];
    int          ptr_m    [ND];
    logic [7:0]  dout_m   [ND][4];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
        end
    endtask

    // First requester from ptr (round-robin) or from port 0 (fixed).
    function automatic int pick(input int d);
        int p;
        for (int k = 0; k < nport_of[d]; k++) begin
            p = (rr_of[d] != 0) ? (ptr_m[d] + k) % nport_of[d] : k;
            if (cs_r[d][p]) return p;
        end
        return -1;
    endfunction

    task automatic reset_model();
        for (int d = 0; d < ND; d++) begin
            ptr_m[d] = 0;
            cs_r[d]  = 4'h0;
            we_r[d]  = 4'h0;
            for (int p = 0; p < 4; p++) begin
                dout_m[d][p] = 8'h00;
                addr_r[d][p] = '0;
                din_r[d][p]  = '0;
            end
        end
    endtask

    task automatic raise(input int d, input int p, input bit we, input int a, input int v);
        cs_r[d][p]   = 1'b1;
        we_r[d][p]   = we;
        addr_r[d][p] = AW'(a);
        din_r[d][p]  = DW'(v);
    endtask

    // Random request; reads only target locations the model knows.
    task automatic rand_raise(input int d, input int p);
        int a;
        bit w;
        a = $urandom_range(0, 16);
        if (a == 16) a = 'h1FFF;
        w = vld_m[d][a] ? 1'($urandom_range(0, 1)) : 1'b1;
        raise(d, p, w, a, $urandom_range(0, 255));
    endtask

    task automatic check_slices(input string tag, input int d, input int skip);
        for (int p = 0; p < nport_of[d]; p++) begin
            if (p != skip) chk(tag, d, dout_w[d][p], dout_m[d][p]);
        end
    endtask

    // One grant, starting at a falling edge with the arbiter idle and at
    // least one request pending; ends at the falling edge after return to
    // idle. mode 1 raises random new requests as the winner drops cs.
    task automatic transact(input int d, input int mode, output int w);
        int         a;
        logic [7:0] ev;
        w = pick(d);
        if (w < 0) return;
        a = int'(addr_r[d][w]);
        if (we_r[d][w]) begin
            mem_m[d][a] = din_r[d][w];
            vld_m[d][a] = 1'b1;
            ev = din_r[d][w];
        end else begin
            ev = mem_m[d][a];
        end
        @(negedge clk);
        chk("access_busy", d, 32'(busy_w[d]), 1);
        chk("access_ok", d, 32'(ok_w[d]), 0);
        @(negedge clk);
        chk("done_ok", d, 32'(ok_w[d]), 32'(1 << w));
        chk("done_busy", d, 32'(busy_w[d]), 1);
        chk("done_dout", d, 32'(dout_w[d][w]), 32'(ev));
        check_slices("done_other_dout", d, w);
        repeat ($urandom_range(0, 2)) begin
            // Winner edits its fields while holding cs: no new access.
            addr_r[d][w] = AW'($urandom_range(0, 15));
            din_r[d][w]  = DW'($urandom_range(0, 255));
            we_r[d][w]   = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("hold_ok", d, 32'(ok_w[d]), 32'(1 << w));
            chk("hold_dout", d, 32'(dout_w[d][w]), 32'(ev));
        end
        cs_r[d][w]   = 1'b0;
        dout_m[d][w] = ev;
        if (rr_of[d] != 0) ptr_m[d] = (w + 1) % nport_of[d];
        if (mode == 1) begin
            for (int p = 0; p < nport_of[d]; p++) begin
                if (p != w && !cs_r[d][p] && $urandom_range(0, 1) == 1) rand_raise(d, p);
            end
        end
        @(negedge clk);
        chk("idle_ok", d, 32'(ok_w[d]), 0);
        chk("idle_busy", d, 32'(busy_w[d]), 0);
        check_slices("idle_dout", d, -1);
    endtask

    initial begin
        int w;
        int a;
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < 8192; i++) vld_m[d][i] = 1'b0;
        end
        reset_model();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk("rst_ok", d, 32'(ok_w[d]), 0);
            chk("rst_busy", d, 32'(busy_w[d]), 0);
            check_slices("rst_dout", d, -1);
        end
        rst = 1'b0;

        // Collision from ptr=0, twice: port 0 first each time.
        raise(0, 0, 1, 'h0020, 'h3C);
        raise(0, 1, 1, 'h0021, 'hC3);
        transact(0, 0, w);
        transact(0, 0, w);
        raise(0, 0, 0, 'h0021, 0);
        raise(0, 1, 0, 'h0020, 0);
        transact(0, 0, w);
        transact(0, 0, w);

        // Single read of a preloaded location.
        raise(0, 1, 1, 'h0123, 'h5A);
        transact(0, 0, w);
        raise(0, 0, 0, 'h0123, 0);
        transact(0, 0, w);

        // Write/readback at the top address.
        raise(0, 1, 1, 'h1FFF, 'hA5);
        transact(0, 0, w);
        raise(0, 0, 0, 'h1FFF, 0);
        transact(0, 0, w);

        // Fairness: both ports re-request right after each grant.
        for (int d = 0; d < 2; d++) begin
            raise(d, 0, 1, 'h0005, 'h55);
            raise(d, 1, 1, 'h0006, 'h66);
            transact(d, 0, w);
            raise(d, w, 1, 'h0005 + w, $urandom_range(0, 255));
            for (int i = 0; i < 19; i++) begin
                transact(d, 0, w);
                raise(d, w, 0, 'h0005 + w, 0);
            end
            // Let the waiting port through: no request is lost.
            cs_r[d] = 4'h0;
            raise(d, 1, 0, 'h0006, 0);
            transact(d, 0, w);
        end

        // Reset during the ACCESS cycle of a write.
        raise(0, 0, 1, 'h0010, 'h11);
        transact(0, 0, w);
        raise(0, 0, 1, 'h0010, 'h77);
        @(negedge clk);
        chk("prerst_busy", 0, 32'(busy_w[0]), 1);
        rst = 1'b1;
        #1;
        chk("midrst_ok", 0, 32'(ok_w[0]), 0);
        chk("midrst_busy", 0, 32'(busy_w[0]), 0);
        reset_model();
        check_slices("midrst_dout", 0, -1);
        @(negedge clk);
        rst = 1'b0;
        raise(0, 0, 0, 'h0010, 0);
        raise(0, 1, 0, 'h0010, 0);
        transact(0, 0, w);
        transact(0, 0, w);

        // Four ports at once.
        for (int p = 0; p < 4; p++) raise(2, p, 1, 'h0100 + p, 'hE0 + p);
        for (int i = 0; i < 4; i++) transact(2, 0, w);
        for (int p = 0; p < 4; p++) raise(2, p, 0, 'h0100 + p, 0);
        for (int i = 0; i < 4; i++) transact(2, 0, w);

        // Random traffic.
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < 60; i++) begin
                if (cs_r[d] == 4'h0) begin
                    a = $urandom_range(0, nport_of[d] - 1);
                    rand_raise(d, a);
                end
                transact(d, 1, w);
            end
            while (cs_r[d] != 4'h0) transact(d, 0, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
